// File: rtl/code_lock_pkg.sv
// Shared state encoding, display glyphs and press-decoding helpers for the code lock.
package code_lock_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_ENTRY   = 2'd0;
    localparam state_t ST_OPEN    = 2'd1;
    localparam state_t ST_PROGRAM = 2'd2;
    localparam state_t ST_LOCKOUT = 2'd3;

    localparam logic [6:0] SEG_LOCK = 7'b1110001;
    localparam logic [6:0] SEG_OPEN = 7'b1000001;
    localparam logic [6:0] SEG_PROG = 7'b0011000;
    localparam logic [6:0] SEG_OUT  = 7'b0000001;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } onehot_t;

    // valid only when exactly one bit is set; idx is then that bit's position
    function automatic onehot_t onehot_idx(input logic [15:0] vec);
        onehot_t     res;
        int unsigned n_set;
        res   = '0;
        n_set = 0;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) begin
                n_set   = n_set + 1;
                res.idx = 4'(i);
            end
        end
        res.valid = (n_set == 1);
        return res;
    endfunction

    function automatic logic [6:0] state_glyph(input state_t st);
        logic [6:0] seg;
        case (st)
            ST_OPEN:    seg = SEG_OPEN;
            ST_PROGRAM: seg = SEG_PROG;
            ST_LOCKOUT: seg = SEG_OUT;
            default:    seg = SEG_LOCK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Per-button two-flop synchronizer followed by a single-cycle rising-edge pulse.
module btn_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_press = r_sync & ~r_prev;

endmodule

// File: rtl/code_lock_ctrl.sv
// Sequence code lock: button entry, wrong-try lockout, entry timeout and in-place reprogramming.
module code_lock_ctrl #(
    parameter int unsigned N_BTN       = 4,
    parameter int unsigned CODE_LEN    = 4,
    parameter logic [CODE_LEN*$clog2(N_BTN)-1:0] DEFAULT_CODE = {2'd0, 2'd1, 2'd2, 2'd3},
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCKOUT_CYC = 100_000_000,
    parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [N_BTN-1:0]                  i_btn,
    input  logic                              i_lock_cmd,
    input  logic                              i_prog_req,
    output logic                              o_unlocked,
    output logic                              o_locked_out,
    output logic                              o_fail,
    output logic [$clog2(CODE_LEN+1)-1:0]     o_digit_cnt,
    output logic [3:0]                        o_tries_left,
    output logic [6:0]                        o_segment
);
    import code_lock_pkg::*;

    localparam int unsigned IDX_W  = $clog2(N_BTN);
    localparam int unsigned CNT_W  = $clog2(CODE_LEN + 1);
    localparam int unsigned CIDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(CODE_LEN - 1);

    logic [N_BTN-1:0] w_press;
    logic [15:0]      w_press_ext;
    onehot_t          w_oh;
    logic             w_press_any;
    logic             w_digit_ok;
    logic [CIDX_W-1:0] w_cnt_idx;
    logic             w_unused_idx;

    state_t           r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_err, w_err_d;
    logic [3:0]       r_tries, w_tries_d;
    logic [31:0]      r_tmr, w_tmr_d;
    logic [31:0]      r_idle, w_idle_d;
    logic             r_fail, w_fail_d;
    logic [6:0]       r_segment;
    logic [IDX_W-1:0] r_code   [CODE_LEN];
    logic [IDX_W-1:0] w_code_d [CODE_LEN];
    logic [IDX_W-1:0] r_shadow [CODE_LEN];
    logic [IDX_W-1:0] w_shadow_d [CODE_LEN];

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_edge u_btn_edge (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_btn   (i_btn[g]),
            .o_press (w_press[g])
        );
    end

    always_comb begin
        w_press_ext              = '0;
        w_press_ext[N_BTN-1:0]   = w_press;
    end

    assign w_oh         = onehot_idx(w_press_ext);
    assign w_press_any  = |w_press;
    assign w_cnt_idx    = r_cnt[CIDX_W-1:0];
    // A multi-button press never matches, so it always marks the attempt wrong.
    assign w_digit_ok   = w_oh.valid && (w_oh.idx[IDX_W-1:0] == r_code[w_cnt_idx]);
    assign w_unused_idx = ^w_oh.idx;

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_err_d    = r_err;
        w_tries_d  = r_tries;
        w_tmr_d    = r_tmr;
        w_idle_d   = r_idle;
        w_fail_d   = 1'b0;
        w_code_d   = r_code;
        w_shadow_d = r_shadow;

        case (r_state)
            ST_ENTRY: begin
                if (w_press_any) begin
                    w_idle_d = '0;
                    if (r_cnt == LAST_DIGIT) begin
                        w_cnt_d = '0;
                        w_err_d = 1'b0;
                        if (r_err || !w_digit_ok) begin
                            w_fail_d  = 1'b1;
                            w_tries_d = r_tries - 4'd1;
                            if (r_tries == 4'd1) begin
                                w_state_d = ST_LOCKOUT;
                                w_tmr_d   = LOCKOUT_CYC - 1;
                            end
                        end else begin
                            w_state_d = ST_OPEN;
                            w_tries_d = 4'(MAX_TRIES);
                        end
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                        w_err_d = r_err | ~w_digit_ok;
                    end
                end else if (r_cnt != '0) begin
                    if (r_idle == TIMEOUT_CYC - 1) begin
                        w_cnt_d  = '0;
                        w_err_d  = 1'b0;
                        w_idle_d = '0;
                    end else begin
                        w_idle_d = r_idle + 32'd1;
                    end
                end
            end
            ST_OPEN: begin
                if (i_lock_cmd) begin
                    w_state_d = ST_ENTRY;
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                end else if (i_prog_req) begin
                    w_state_d  = ST_PROGRAM;
                    w_cnt_d    = '0;
                    w_shadow_d = r_code;
                end
            end
            ST_PROGRAM: begin
                // Abort restores the code captured on entry, discarding partial writes.
                if (i_lock_cmd) begin
                    w_state_d = ST_ENTRY;
                    w_code_d  = r_shadow;
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                end else if (w_oh.valid) begin
                    w_code_d[w_cnt_idx] = w_oh.idx[IDX_W-1:0];
                    if (r_cnt == LAST_DIGIT) begin
                        w_cnt_d   = '0;
                        w_state_d = ST_OPEN;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_LOCKOUT: begin
                if (r_tmr == '0) begin
                    w_state_d = ST_ENTRY;
                    w_tries_d = 4'(MAX_TRIES);
                end else begin
                    w_tmr_d = r_tmr - 32'd1;
                end
            end
            default: w_state_d = ST_ENTRY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_ENTRY;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_tries   <= 4'(MAX_TRIES);
            r_tmr     <= '0;
            r_idle    <= '0;
            r_fail    <= 1'b0;
            r_segment <= SEG_LOCK;
            for (int i = 0; i < CODE_LEN; i++) begin
                r_code[i]   <= DEFAULT_CODE[i*IDX_W +: IDX_W];
                r_shadow[i] <= DEFAULT_CODE[i*IDX_W +: IDX_W];
            end
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_err     <= w_err_d;
            r_tries   <= w_tries_d;
            r_tmr     <= w_tmr_d;
            r_idle    <= w_idle_d;
            r_fail    <= w_fail_d;
            r_segment <= state_glyph(w_state_d);
            r_code    <= w_code_d;
            r_shadow  <= w_shadow_d;
        end
    end

    assign o_unlocked   = (r_state == ST_OPEN) || (r_state == ST_PROGRAM);
    assign o_locked_out = (r_state == ST_LOCKOUT);
    assign o_fail       = r_fail;
    assign o_digit_cnt  = r_cnt;
    assign o_tries_left = r_tries;
    assign o_segment    = r_segment;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Randomized bench for code_lock_ctrl against an event-level model of the lock's rules.
module tb_code_lock_ctrl;

    localparam int N_BTN       = 4;
    localparam int CODE_LEN    = 4;
    localparam int MAX_TRIES   = 3;
    localparam int LOCKOUT_CYC = 20;
    localparam int TIMEOUT_CYC = 50;

    localparam logic [6:0] G_LOCK = 7'b1110001;
    localparam logic [6:0] G_OPEN = 7'b1000001;
    localparam logic [6:0] G_PROG = 7'b0011000;
    localparam logic [6:0] G_OUT  = 7'b0000001;

    localparam int M_ENTRY = 0, M_OPEN = 1, M_PROGRAM = 2, M_LOCKOUT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       lock_cmd;
    logic       prog_req;
    logic       unlocked;
    logic       locked_out;
    logic       fail;
    logic [2:0] digit_cnt;
    logic [3:0] tries_left;
    logic [6:0] segment;

    always #5 clk = ~clk;

    code_lock_ctrl #(
        .N_BTN       (N_BTN),
        .CODE_LEN    (CODE_LEN),
        .MAX_TRIES   (MAX_TRIES),
        .LOCKOUT_CYC (LOCKOUT_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_btn        (btn),
        .i_lock_cmd   (lock_cmd),
        .i_prog_req   (prog_req),
        .o_unlocked   (unlocked),
        .o_locked_out (locked_out),
        .o_fail       (fail),
        .o_digit_cnt  (digit_cnt),
        .o_tries_left (tries_left),
        .o_segment    (segment)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int fail_seen = 0;
    int lo_seen   = 0;

    always @(negedge clk) begin
        if (fail === 1'b1)       fail_seen <= fail_seen + 1;
        if (locked_out === 1'b1) lo_seen   <= lo_seen + 1;
    end

    // Reference model, advanced one whole press/command at a time
    int m_state, m_cnt, m_err, m_tries, m_fail;
    int m_code [CODE_LEN];
    int m_pend [CODE_LEN];

    function automatic logic [6:0] glyph(input int s);
        case (s)
            M_OPEN:    return G_OPEN;
            M_PROGRAM: return G_PROG;
            M_LOCKOUT: return G_OUT;
            default:   return G_LOCK;
        endcase
    endfunction

    function automatic logic [15:0] expv();
        return {(m_state == M_OPEN) || (m_state == M_PROGRAM), m_state == M_LOCKOUT,
                3'(m_cnt), 4'(m_tries), glyph(m_state)};
    endfunction

    function automatic logic [15:0] obsv();
        return {unlocked, locked_out, digit_cnt, tries_left, segment};
    endfunction

    task automatic model_reset();
        m_state = M_ENTRY; m_cnt = 0; m_err = 0; m_tries = MAX_TRIES;
        m_code  = '{3, 2, 1, 0};
    endtask

    task automatic model_press(input logic [3:0] mask);
        int ones, idx;
        ones = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (mask[i]) begin ones++; idx = i; end
        case (m_state)
            M_ENTRY: begin
                if (ones != 1 || idx != m_code[m_cnt]) m_err = 1;
                m_cnt++;
                if (m_cnt == CODE_LEN) begin
                    m_cnt = 0;
                    if (m_err != 0) begin
                        m_fail++; m_tries--;
                        if (m_tries == 0) m_state = M_LOCKOUT;
                    end else begin
                        m_state = M_OPEN; m_tries = MAX_TRIES;
                    end
                    m_err = 0;
                end
            end
            M_PROGRAM: begin
                if (ones == 1) begin
                    m_pend[m_cnt] = idx; m_cnt++;
                    if (m_cnt == CODE_LEN) begin
                        m_cnt = 0; m_code = m_pend; m_state = M_OPEN;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic press(input logic [3:0] mask, input int hold, input int gap);
        @(negedge clk) btn = mask;
        repeat (hold) @(negedge clk);
        btn = 4'b0;
        model_press(mask);
        repeat (gap) @(negedge clk);
    endtask

    task automatic rpress(input logic [3:0] mask);
        press(mask, $urandom_range(3, 6), $urandom_range(3, 6));
    endtask

    task automatic enter(input int a, input int b, input int c, input int d);
        rpress(4'(1 << a)); rpress(4'(1 << b)); rpress(4'(1 << c)); rpress(4'(1 << d));
    endtask

    task automatic do_lock();
        @(negedge clk) lock_cmd = 1'b1;
        @(negedge clk) lock_cmd = 1'b0;
        if (m_state == M_OPEN || m_state == M_PROGRAM) begin
            m_state = M_ENTRY; m_cnt = 0; m_err = 0;
        end
    endtask

    task automatic do_prog();
        @(negedge clk) prog_req = 1'b1;
        @(negedge clk) prog_req = 1'b0;
        if (m_state == M_OPEN) begin m_state = M_PROGRAM; m_cnt = 0; end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_lockout_end();
        for (int i = 0; i < 200 && locked_out === 1'b1; i++) @(negedge clk);
        n_checks++;
        if (locked_out !== 1'b0) begin
            n_fail++; $display("FAIL lockout_exit: locked_out=%b after 200 cycles, want 0", locked_out);
        end
        m_state = M_ENTRY; m_tries = MAX_TRIES; m_cnt = 0; m_err = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        n_checks++;
        if (obsv() !== expv() || fail !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got %h fail=%b want %h fail=0", obsv(), fail, expv());
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_unlock();
        press(4'b1000, 5, 5); press(4'b0100, 5, 5); press(4'b0010, 5, 5);
        n_checks++;
        if (obsv() !== expv()) begin
            n_fail++; $display("FAIL basic_three_digits: got %h want %h", obsv(), expv());
        end
        press(4'b0001, 5, 5);
        n_checks++;
        if (obsv() !== expv() || segment !== G_OPEN || tries_left !== 4'd3) begin
            n_fail++; $display("FAIL basic_unlock: got %h want %h", obsv(), expv());
        end
        n_checks++;
        if (fail_seen !== 0) begin
            n_fail++; $display("FAIL basic_no_fail: fail pulses=%0d want 0", fail_seen);
        end
        do_lock();
        n_checks++;
        if (obsv() !== expv()) begin
            n_fail++; $display("FAIL basic_relock: got %h want %h", obsv(), expv());
        end
    endtask

    task automatic test_wrong_lockout();
        int lo0;
        for (int a = 0; a < 3; a++) begin
            rpress(4'b1000); rpress(4'b0100); rpress(4'b0010);
            lo0 = lo_seen;
            if (a == 2) press(4'b0010, 3, 3);
            else rpress(4'b0010);
            n_checks++;
            if (obsv() !== expv() || tries_left !== 4'(2 - a)) begin
                n_fail++; $display("FAIL wrong_attempt_%0d: got %h want %h", a, obsv(), expv());
            end
            n_checks++;
            if (fail_seen !== m_fail) begin
                n_fail++; $display("FAIL wrong_fail_count: got %0d want %0d", fail_seen, m_fail);
            end
        end
        press(4'b1000, 3, 3);
        n_checks++;
        if (digit_cnt !== 3'd0 || locked_out !== 1'b1) begin
            n_fail++; $display("FAIL lockout_ignores_press: cnt=%0d lo=%b want 0/1", digit_cnt, locked_out);
        end
        wait_lockout_end();
        n_checks++;
        if (lo_seen - lo0 !== LOCKOUT_CYC) begin
            n_fail++; $display("FAIL lockout_dwell: got %0d cycles want %0d", lo_seen - lo0, LOCKOUT_CYC);
        end
        n_checks++;
        if (obsv() !== expv()) begin
            n_fail++; $display("FAIL lockout_recover: got %h want %h", obsv(), expv());
        end
    endtask

    task automatic test_simultaneous();
        rpress(4'b1100); rpress(4'b0100); rpress(4'b0010); rpress(4'b0001);
        n_checks++;
        if (obsv() !== expv() || fail_seen !== m_fail || tries_left !== 4'd2) begin
            n_fail++; $display("FAIL simultaneous_press: got %h/%0d want %h/%0d", obsv(), fail_seen,
                               expv(), m_fail);
        end
        enter(3, 2, 1, 0);
        n_checks++;
        if (obsv() !== expv()) begin
            n_fail++; $display("FAIL simultaneous_recover: got %h want %h", obsv(), expv());
        end
        do_lock();
    endtask

    task automatic test_reprogram();
        enter(3, 2, 1, 0);
        do_prog();
        n_checks++;
        if (obsv() !== expv()) begin
            n_fail++; $display("FAIL prog_enter: got %h want %h", obsv(), expv());
        end
        rpress(4'b0011);
        enter(0, 0, 1, 1);
        n_checks++;
        if (obsv() !== expv()) begin
            n_fail++; $display("FAIL prog_done: got %h want %h", obsv(), expv());
        end
        do_lock();
        enter(3, 2, 1, 0);
        n_checks++;
        if (obsv() !== expv() || fail_seen !== m_fail) begin
            n_fail++; $display("FAIL prog_old_rejected: got %h want %h", obsv(), expv());
        end
        enter(0, 0, 1, 1);
        n_checks++;
        if (obsv() !== expv() || unlocked !== 1'b1) begin
            n_fail++; $display("FAIL prog_new_accepted: got %h want %h", obsv(), expv());
        end
        do_lock();
        do_reset();
        enter(3, 2, 1, 0);
        n_checks++;
        if (obsv() !== expv() || unlocked !== 1'b1) begin
            n_fail++; $display("FAIL prog_reset_default: got %h want %h", obsv(), expv());
        end
        do_lock();
    endtask

    task automatic test_abort_timeout();
        enter(3, 2, 1, 0);
        do_prog();
        rpress(4'b0001); rpress(4'b0001);
        n_checks++;
        if (obsv() !== expv()) begin
            n_fail++; $display("FAIL abort_partial: got %h want %h", obsv(), expv());
        end
        do_lock();
        enter(3, 2, 1, 0);
        n_checks++;
        if (obsv() !== expv() || unlocked !== 1'b1) begin
            n_fail++; $display("FAIL abort_old_code: got %h want %h", obsv(), expv());
        end
        do_lock();
        press(4'b1000, 3, 3);
        repeat (40) @(negedge clk);
        n_checks++;
        if (obsv() !== expv() || digit_cnt !== 3'd1) begin
            n_fail++; $display("FAIL timeout_early: got %h want %h", obsv(), expv());
        end
        repeat (10) @(negedge clk);
        m_cnt = 0; m_err = 0;
        n_checks++;
        if (obsv() !== expv() || fail_seen !== m_fail) begin
            n_fail++; $display("FAIL timeout_clear: got %h want %h", obsv(), expv());
        end
    endtask

    task automatic test_held_reset();
        @(negedge clk) btn = 4'b1000;
        repeat (40) @(negedge clk);
        model_press(4'b1000);
        n_checks++;
        if (digit_cnt !== 3'd1) begin
            n_fail++; $display("FAIL held_single_press: got %0d want 1", digit_cnt);
        end
        repeat (160) @(negedge clk);
        btn = 4'b0;
        repeat (5) @(negedge clk);
        m_cnt = 0; m_err = 0;
        n_checks++;
        if (obsv() !== expv()) begin
            n_fail++; $display("FAIL held_timeout: got %h want %h", obsv(), expv());
        end
        enter(0, 0, 0, 0);
        rpress(4'b1000); rpress(4'b0100);
        n_checks++;
        if (obsv() !== expv()) begin
            n_fail++; $display("FAIL pre_reset_partial: got %h want %h", obsv(), expv());
        end
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        model_reset();
        n_checks++;
        if (digit_cnt !== 3'd0 || tries_left !== 4'd3 || segment !== G_LOCK) begin
            n_fail++; $display("FAIL mid_reset: got cnt=%0d tries=%0d seg=%b want 0/3/%b", digit_cnt,
                               tries_left, segment, G_LOCK);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int d [CODE_LEN];
        logic [3:0] mask;
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 2) == 0) d = m_code;
            else for (int j = 0; j < CODE_LEN; j++) d[j] = $urandom_range(0, 3);
            for (int j = 0; j < CODE_LEN; j++) begin
                mask = 4'(1 << d[j]);
                if ($urandom_range(0, 7) == 0) mask = 4'b0101;
                rpress(mask);
            end
            n_checks++;
            if (obsv() !== expv() || fail_seen !== m_fail) begin
                n_fail++; $display("FAIL random_%0d: got %h/%0d want %h/%0d", it, obsv(), fail_seen,
                                   expv(), m_fail);
            end
            if (m_state == M_OPEN) do_lock();
            else if (m_state == M_LOCKOUT) wait_lockout_end();
        end
    endtask

    initial begin
        rst = 1'b1; btn = 4'b0; lock_cmd = 1'b0; prog_req = 1'b0;
        m_fail = 0;
        model_reset();
        test_reset();
        test_basic_unlock();
        test_wrong_lockout();
        test_simultaneous();
        test_reprogram();
        test_abort_timeout();
        test_held_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
